// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that sequences one master request at a time onto a decoded slave bus.
// Latency: accept T -> bus_valid_o T+1 -> rsp_valid_o T+3 for a zero-wait hit; a decode miss answers at T+2.
// Backpressure: req_ready_o only while IDLE; the slave stalls via bus_ready_i and bus_rsp_valid_i.
// Build option: define BUS_ARB_TIMEOUT_EN to bound REQ+RSP at TIMEOUT_CYC cycles (ends with err=1).
module bus_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned N_MASTERS   = 4,
    parameter int unsigned N_SLAVES    = 4,
    parameter int unsigned SLAVE_SIZE  = 32'h1000,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_MASTERS-1:0]          req_valid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   req_addr_i,
    input  logic [N_MASTERS-1:0]          req_we_i,
    input  logic [N_MASTERS*DATA_W-1:0]   req_wdata_i,
    output logic [N_MASTERS-1:0]          req_ready_o,
    output logic [N_MASTERS-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          bus_valid_o,
    output logic [N_SLAVES-1:0]           bus_sel_o,
    output logic [ADDR_W-1:0]             bus_addr_o,
    output logic                          bus_we_o,
    output logic [DATA_W-1:0]             bus_wdata_o,
    input  logic                          bus_ready_i,
    input  logic                          bus_rsp_valid_i,
    input  logic [DATA_W-1:0]             bus_rsp_rdata_i
);

    localparam int unsigned MW    = $clog2(N_MASTERS);
    localparam int unsigned OFF_W = $clog2(SLAVE_SIZE);

    typedef enum logic [2:0] {IDLE, REQ, RSP, ERR, DONE} state_t;

    // Everything about the accepted request that the bus side needs later.
    typedef struct packed {
        logic [ADDR_W-1:0]   offs;
        logic [N_SLAVES-1:0] sel;
        logic                we;
        logic [DATA_W-1:0]   wdata;
        logic [MW-1:0]       gnt;
    } req_t;

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic [MW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              gnt_vld;
    logic [MW-1:0]     gnt_idx;
    logic [MW-1:0]     cand;
    logic [ADDR_W-1:0] gnt_addr;
    logic [ADDR_W-1:0] slv_idx;
    logic              dec_hit;
    logic [N_SLAVES-1:0] dec_sel;
    logic [MW-1:0]     rr_next;
    logic              bus_act;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_hit;
    // Counter value k means the transfer has spent k cycles in REQ/RSP before this one.
    assign to_hit = (to_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    // Pick the first requester at or after rr_ptr_q, wrapping around the master list.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            cand = MW'((int'(rr_ptr_q) + i) % int'(N_MASTERS));
            if (!gnt_vld && req_valid_i[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_addr = req_addr_i[int'(gnt_idx) * int'(ADDR_W) +: ADDR_W];

    // Uniform map: the window index is simply the address above the offset bits.
    assign slv_idx = gnt_addr >> OFF_W;
    assign dec_hit = (slv_idx < ADDR_W'(N_SLAVES));

    // One-hot select; stays all-zero on a miss because no index matches.
    always_comb begin
        dec_sel = '0;
        for (int k = 0; k < int'(N_SLAVES); k++) begin
            dec_sel[k] = (slv_idx == ADDR_W'(k));
        end
    end

    assign rr_next = (req_q.gnt == MW'(N_MASTERS - 1)) ? '0 : req_q.gnt + 1'b1;

    // Next-state and accept logic; grants are blocked while reset is held so no master sees a phantom accept.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rr_ptr_d    = rr_ptr_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = '0;
`ifdef BUS_ARB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld && !rst_i) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    req_d.offs  = gnt_addr & ADDR_W'(SLAVE_SIZE - 1);
                    req_d.sel   = dec_sel;
                    req_d.we    = req_we_i[gnt_idx];
                    req_d.wdata = req_wdata_i[int'(gnt_idx) * int'(DATA_W) +: DATA_W];
                    req_d.gnt   = gnt_idx;
                    state_d     = dec_hit ? REQ : ERR;
`ifdef BUS_ARB_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                end
            end
            REQ: begin
`ifdef BUS_ARB_TIMEOUT_EN
                if (to_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (bus_ready_i) begin
                        state_d = RSP;
                    end
                end
`else
                if (bus_ready_i) begin
                    state_d = RSP;
                end
`endif
            end
            RSP: begin
                // A response arriving on the last allowed cycle still wins over the timeout.
                if (bus_rsp_valid_i) begin
                    rdata_d = bus_rsp_rdata_i;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            ERR: begin
                rdata_d = '0;
                err_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                rr_ptr_d = rr_next;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request, pointer and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            req_q    <= '0;
            rr_ptr_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            rr_ptr_q <= rr_ptr_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Watchdog counter for the bus phases.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // Bus fields are shown only while a hit is in flight, so misses and idle cycles stay quiet.
    assign bus_act     = (state_q == REQ) || (state_q == RSP);
    assign bus_valid_o = (state_q == REQ);
    assign bus_sel_o   = bus_act ? req_q.sel   : '0;
    assign bus_addr_o  = bus_act ? req_q.offs  : '0;
    assign bus_we_o    = bus_act ? req_q.we    : 1'b0;
    assign bus_wdata_o = bus_act ? req_q.wdata : '0;

    // Single-cycle response pulse back to the granted master.
    always_comb begin
        rsp_valid_o = '0;
        if (state_q == DONE) begin
            rsp_valid_o[req_q.gnt] = 1'b1;
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus for bus_arbiter with a response scoreboard.
// Expected responses are queued at accept time; a monitor pops them when rsp_valid_o fires.
// Cycle-exact checks cover latency, stall stability, reset abort and round-robin order.
module tb_bus_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [NM-1:0]    req_valid_i;
    logic [NM*AW-1:0] req_addr_i;
    logic [NM-1:0]    req_we_i;
    logic [NM*DW-1:0] req_wdata_i;
    logic [NM-1:0]    req_ready_o;
    logic [NM-1:0]    rsp_valid_o;
    logic [DW-1:0]    rsp_rdata_o;
    logic             rsp_err_o;
    logic             bus_valid_o;
    logic [NS-1:0]    bus_sel_o;
    logic [AW-1:0]    bus_addr_o;
    logic             bus_we_o;
    logic [DW-1:0]    bus_wdata_o;
    logic             bus_ready_i;
    logic             bus_rsp_valid_i;
    logic [DW-1:0]    bus_rsp_rdata_i;

    bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .N_MASTERS(NM), .N_SLAVES(NS),
        .SLAVE_SIZE(32'h1000), .TIMEOUT_CYC(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_we_i(req_we_i),
        .req_wdata_i(req_wdata_i), .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .bus_valid_o(bus_valid_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
        .bus_we_o(bus_we_o), .bus_wdata_o(bus_wdata_o), .bus_ready_i(bus_ready_i),
        .bus_rsp_valid_i(bus_rsp_valid_i), .bus_rsp_rdata_i(bus_rsp_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NM-1:0] mst;
        logic [DW-1:0] rdata;
        logic          err;
        bit            chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [NM-1:0] m, input logic [DW-1:0] d, input logic e, input bit cd);
        exp_t x;
        x.mst      = m;
        x.rdata    = d;
        x.err      = e;
        x.chk_data = cd;
        exp_q.push_back(x);
    endtask

    task automatic set_req(input int m, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        req_addr_i[m*AW +: AW]  = a;
        req_we_i[m]             = w;
        req_wdata_i[m*DW +: DW] = d;
        req_valid_i[m]          = 1'b1;
    endtask

    // Bounded wait for an accept; the caller's compare on req_ready_o flags an expired bound.
    task automatic wait_ready(input logic [NM-1:0] mask);
        int n;
        n = 0;
        #1;
        while ((req_ready_o & mask) == '0 && n < 40) begin
            step();
            n++;
        end
    endtask

    // Scoreboard monitor: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rsp_valid_o != '0) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid_o, '0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rsp_master", rsp_valid_o, e.mst);
                chk("sb_rsp_err", rsp_err_o, e.err);
                if (e.chk_data) chk("sb_rsp_rdata", rsp_rdata_o, e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NM-1:0] oh;
        int last;
        rst_i = 1'b1;
        req_valid_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0;
        bus_ready_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_rdata_i = '0;
        last = 0;
        repeat (3) step();
        chk("reset_outputs", {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, bus_valid_o,
                              bus_sel_o, bus_addr_o, bus_we_o, bus_wdata_o}, '0);
        rst_i = 1'b0;
        step();

        // Single read: master 2 to slave 1, offset 4.
        set_req(2, 32'h0000_1004, 1'b0, '0);
        wait_ready(4'b0100);
        chk("rd_ready", req_ready_o, 4'b0100);
        push_exp(4'b0100, 32'hDEAD_BEEF, 1'b0, 1'b1);
        step();
        req_valid_i[2] = 1'b0;
        chk("rd_bus_valid", bus_valid_o, 1'b1);
        chk("rd_bus_sel", bus_sel_o, 4'b0010);
        chk("rd_bus_addr", bus_addr_o, 32'h004);
        chk("rd_bus_we", bus_we_o, 1'b0);
        bus_ready_i = 1'b1;
        step();
        bus_ready_i = 1'b0;
        chk("rd_bus_valid_drop", bus_valid_o, 1'b0);
        bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = 32'hDEAD_BEEF;
        step();
        bus_rsp_valid_i = 1'b0; bus_rsp_rdata_i = '0;
        chk("rd_rsp_latency", rsp_valid_o, 4'b0100);
        step();
        chk("rd_rsp_one_pulse", rsp_valid_o, 4'b0000);

        // Decode miss at the first address past the map.
        set_req(0, 32'h0000_4000, 1'b0, '0);
        wait_ready(4'b0001);
        chk("miss_ready", req_ready_o, 4'b0001);
        push_exp(4'b0001, 32'h0, 1'b1, 1'b1);
        step();
        req_valid_i[0] = 1'b0;
        chk("miss_no_bus", bus_valid_o, 1'b0);
        step();
        chk("miss_rsp_latency", rsp_valid_o, 4'b0001);
        step();

`ifndef BUS_ARB_TIMEOUT_EN
        // Slave stall: ready low 5 cycles, response 3 cycles after ready; master 0 competes meanwhile.
        set_req(3, 32'h0000_2008, 1'b0, '0);
        wait_ready(4'b1000);
        chk("stall_ready", req_ready_o, 4'b1000);
        push_exp(4'b1000, 32'h0BAD_F00D, 1'b0, 1'b1);
        step();
        req_valid_i[3] = 1'b0;
        set_req(0, 32'h0000_0000, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_bus_valid", bus_valid_o, 1'b1);
            chk("stall_bus_sel", bus_sel_o, 4'b0100);
            chk("stall_bus_addr", bus_addr_o, 32'h008);
            chk("stall_no_ready", req_ready_o, 4'b0000);
            step();
        end
        chk("stall_bus_valid_last", bus_valid_o, 1'b1);
        bus_ready_i = 1'b1;
        step();
        bus_ready_i = 1'b0;
        #1;
        chk("stall_no_ready_rsp", req_ready_o, 4'b0000);
        step();
        chk("stall_no_ready_rsp2", req_ready_o, 4'b0000);
        req_valid_i[0] = 1'b0;
        step();
        chk("stall_rsp_not_early", rsp_valid_o, 4'b0000);
        bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = 32'h0BAD_F00D;
        step();
        bus_rsp_valid_i = 1'b0; bus_rsp_rdata_i = '0;
        chk("stall_rsp", rsp_valid_o, 4'b1000);
        step();
        chk("stall_rsp_one_pulse", rsp_valid_o, 4'b0000);
`else
        // Timeout: slave takes the request but never answers.
        set_req(2, 32'h0000_0100, 1'b0, '0);
        wait_ready(4'b0100);
        chk("to_ready", req_ready_o, 4'b0100);
        push_exp(4'b0100, 32'h0, 1'b1, 1'b1);
        step();
        req_valid_i[2] = 1'b0;
        chk("to_bus_valid", bus_valid_o, 1'b1);
        bus_ready_i = 1'b1;
        step();
        bus_ready_i = 1'b0;
        repeat (6) step();
        chk("to_not_early", rsp_valid_o, 4'b0000);
        step();
        chk("to_rsp", rsp_valid_o, 4'b0100);
        chk("to_bus_idle", bus_valid_o, 1'b0);
        step();
        bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = 32'hFFFF_FFFF;
        step();
        bus_rsp_valid_i = 1'b0; bus_rsp_rdata_i = '0;
        chk("to_late_ignored", rsp_valid_o, 4'b0000);
`endif

        // Write to slave 3; read data in the response is don't-care.
        set_req(1, 32'h0000_3010, 1'b1, 32'hCAFE_F00D);
        wait_ready(4'b0010);
        chk("wr_ready", req_ready_o, 4'b0010);
        push_exp(4'b0010, 32'h0, 1'b0, 1'b0);
        step();
        req_valid_i[1] = 1'b0; req_we_i[1] = 1'b0;
        chk("wr_bus_sel", bus_sel_o, 4'b1000);
        chk("wr_bus_addr", bus_addr_o, 32'h010);
        chk("wr_bus_we", bus_we_o, 1'b1);
        chk("wr_bus_wdata", bus_wdata_o, 32'hCAFE_F00D);
        bus_ready_i = 1'b1;
        step();
        bus_ready_i = 1'b0;
        bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = 32'h1234_5678;
        step();
        bus_rsp_valid_i = 1'b0; bus_rsp_rdata_i = '0;
        chk("wr_rsp", rsp_valid_o, 4'b0010);
        step();

        // Reset while waiting for the slave response (pointer is 2 here, not 0).
        set_req(2, 32'h0000_0040, 1'b0, '0);
        wait_ready(4'b0100);
        chk("rst_pre_ready", req_ready_o, 4'b0100);
        step();
        req_valid_i[2] = 1'b0;
        bus_ready_i = 1'b1;
        step();
        bus_ready_i = 1'b0;
        step();
        for (int m = 0; m < NM; m++) set_req(m, AW'(m * 32'h1000 + 32'h20), 1'b0, '0);
        rst_i = 1'b1;
        step();
        chk("rst_outputs", {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, bus_valid_o,
                            bus_sel_o, bus_addr_o, bus_we_o, bus_wdata_o}, '0);
        rst_i = 1'b0;

        // Round-robin with every master requesting and a zero-wait slave.
        bus_ready_i = 1'b1; bus_rsp_valid_i = 1'b1; bus_rsp_rdata_i = 32'h5A5A_0000;
        for (int k = 0; k < 5; k++) begin
            wait_ready(4'b1111);
            oh = 4'b0001 << (k % NM);
            chk($sformatf("rr_grant_%0d", k), req_ready_o, oh);
            if (k > 0) chk("rr_interval", cyc - last, 4);
            last = cyc;
            push_exp(oh, 32'h5A5A_0000, 1'b0, 1'b1);
            step();
        end
        req_valid_i = '0;
        repeat (4) step();
        bus_ready_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_rdata_i = '0;
        repeat (3) step();
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
